// File: rtl/pipe_seq_ctrl.sv
// Stall/bubble sequencer for the stage-latch pipeline (load-use, multicycle EX, redirect, memory wait).
// Define PIPE_SEQ_CTRL_PERF_EN to add saturating stall/flush cycle counters.
//
// state | meaning
// RUN   | all latches advance, no bubbles
// LU    | one-cycle load-use stall: stages below HAZ_STG hold, HAZ_STG gets a bubble
// MC    | multicycle execute: stages 0..EX_STG hold, EX_STG+1 gets bubbles
// FLUSH | redirect: youngest FLUSH_DEPTH stages load bubbles
module pipe_seq_ctrl #(
  parameter int NUM_STG     = 6,
  parameter int HAZ_STG     = 2,
  parameter int EX_STG      = 3,
  parameter int MC_LAT      = 4,
  parameter int FLUSH_DEPTH = 3
) (
  input  logic               iw_clk,
  input  logic               iw_rst_n,
  input  logic               iw_ld_use,
  input  logic               iw_mc_start,
  input  logic               iw_branch_taken,
  input  logic               iw_mem_wait,
  output logic [NUM_STG-1:0] ow_stall,
  output logic [NUM_STG-1:0] ow_flush,
  output logic               ow_pc_hold,
  output logic               ow_busy,
  output logic [1:0]         ow_state
`ifdef PIPE_SEQ_CTRL_PERF_EN
  ,
  output logic [31:0]        ow_stall_cnt,
  output logic [31:0]        ow_flush_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LU    = 2'd1,
    ST_MC    = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  localparam logic [NUM_STG-1:0] ONE      = {{(NUM_STG-1){1'b0}}, 1'b1};
  localparam logic [NUM_STG-1:0] LU_STALL = (ONE << HAZ_STG) - ONE;
  localparam logic [NUM_STG-1:0] LU_FLUSH = ONE << HAZ_STG;
  localparam logic [NUM_STG-1:0] MC_STALL = (ONE << (EX_STG + 1)) - ONE;
  // Shifting past the top stage yields zero, so no bubble when EX is the last latch.
  localparam logic [NUM_STG-1:0] MC_FLUSH = ONE << (EX_STG + 1);
  localparam logic [NUM_STG-1:0] FL_FLUSH = (ONE << FLUSH_DEPTH) - ONE;
  localparam logic [3:0]         MC_LOAD  = 4'(MC_LAT - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       freeze;

  // Gated by reset so outputs read zero while reset is held, whatever mem_wait does.
  assign freeze = iw_mem_wait & iw_rst_n;

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ow_stall = '0;
    ow_flush = '0;
    unique case (state_q)
      ST_RUN: begin
        if (iw_branch_taken) begin
          state_d = ST_FLUSH;
        end else if (iw_mc_start) begin
          state_d = ST_MC;
          cnt_d   = MC_LOAD;
        end else if (iw_ld_use) begin
          state_d = ST_LU;
        end
      end
      ST_LU: begin
        ow_stall = LU_STALL;
        ow_flush = LU_FLUSH;
        state_d  = iw_branch_taken ? ST_FLUSH : ST_RUN;
      end
      ST_MC: begin
        ow_stall = MC_STALL;
        ow_flush = MC_FLUSH;
        cnt_d    = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = ST_RUN;
      end
      ST_FLUSH: begin
        ow_flush = FL_FLUSH;
        state_d  = iw_branch_taken ? ST_FLUSH : ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    if (freeze) begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ow_stall = '1;
      ow_flush = '0;
    end
  end

  assign ow_pc_hold = ow_stall[0];
  assign ow_busy    = (state_q != ST_RUN);
  assign ow_state   = state_q;

`ifdef PIPE_SEQ_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((|ow_stall) && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    if ((|ow_flush) && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ow_stall_cnt = stall_cnt_q;
  assign ow_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Scoreboard bench for pipe_seq_ctrl: a mode/remaining-cycles reference model predicts each cycle's outputs.
module tb_pipe_seq_ctrl;
  localparam int NUM_STG     = 6;
  localparam int HAZ_STG     = 2;
  localparam int EX_STG      = 3;
  localparam int MC_LAT      = 4;
  localparam int FLUSH_DEPTH = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic ld_use = 1'b0, mc_start = 1'b0, branch_taken = 1'b0, mem_wait = 1'b0;
  logic [NUM_STG-1:0] ow_stall, ow_flush;
  logic ow_pc_hold, ow_busy;
  logic [1:0] ow_state;
`ifdef PIPE_SEQ_CTRL_PERF_EN
  logic [31:0] ow_stall_cnt, ow_flush_cnt;
`endif

  pipe_seq_ctrl #(
    .NUM_STG(NUM_STG), .HAZ_STG(HAZ_STG), .EX_STG(EX_STG),
    .MC_LAT(MC_LAT), .FLUSH_DEPTH(FLUSH_DEPTH)
  ) dut (
    .iw_clk(clk),
    .iw_rst_n(rst_n),
    .iw_ld_use(ld_use),
    .iw_mc_start(mc_start),
    .iw_branch_taken(branch_taken),
    .iw_mem_wait(mem_wait),
    .ow_stall(ow_stall),
    .ow_flush(ow_flush),
    .ow_pc_hold(ow_pc_hold),
    .ow_busy(ow_busy),
    .ow_state(ow_state)
`ifdef PIPE_SEQ_CTRL_PERF_EN
    ,
    .ow_stall_cnt(ow_stall_cnt),
    .ow_flush_cnt(ow_flush_cnt)
`endif
  );

  typedef struct packed {
    logic [NUM_STG-1:0] stall;
    logic [NUM_STG-1:0] flush;
    logic               pc_hold;
    logic               busy;
    logic [1:0]         state;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: 0=RUN 1=LU 2=MC 3=FLUSH, plus MC cycles still to serve.
  int m_mode = 0;
  int m_left = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic exp_t predict(input logic rst, input logic mw, input int mode);
    exp_t e;
    e = '0;
    if (!rst) return e;
    if (mw) begin
      e.stall = '1;
    end else begin
      case (mode)
        1: begin
          for (int i = 0; i < HAZ_STG; i++) e.stall[i] = 1'b1;
          e.flush[HAZ_STG] = 1'b1;
        end
        2: begin
          for (int i = 0; i <= EX_STG; i++) e.stall[i] = 1'b1;
          for (int i = EX_STG + 1; i < NUM_STG && i == EX_STG + 1; i++) e.flush[i] = 1'b1;
        end
        3: for (int i = 0; i < FLUSH_DEPTH; i++) e.flush[i] = 1'b1;
        default: ;
      endcase
    end
    e.pc_hold = e.stall[0];
    e.busy    = (mode != 0);
    e.state   = 2'(mode);
    return e;
  endfunction

  // One clock: drive inputs after negedge, queue the prediction, advance the model at posedge.
  task automatic cycle(input logic ld, input logic mc, input logic br, input logic mw);
    @(negedge clk);
    #1;
    ld_use = ld; mc_start = mc; branch_taken = br; mem_wait = mw;
    if (!rst_n) begin m_mode = 0; m_left = 0; end
    sb.push_back(predict(rst_n, mw, m_mode));
    @(posedge clk);
    if (!rst_n) begin
      m_mode = 0; m_left = 0;
    end else if (!mw) begin
      case (m_mode)
        0: if (br) m_mode = 3;
           else if (mc) begin m_mode = 2; m_left = MC_LAT - 1; end
           else if (ld) m_mode = 1;
        1: m_mode = br ? 3 : 0;
        2: begin m_left--; if (m_left == 0) m_mode = 0; end
        3: m_mode = br ? 3 : 0;
        default: m_mode = 0;
      endcase
    end
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sb_stall", 32'(ow_stall), 32'(e.stall));
        check("sb_flush", 32'(ow_flush), 32'(e.flush));
        check("sb_ctl", {29'd0, ow_pc_hold, ow_state}, {29'd0, e.pc_hold, e.state});
        check("sb_busy", 32'(ow_busy), 32'(e.busy));
        check("sb_exclusive", 32'(ow_stall & ow_flush), 32'd0);
      end
    end
  end

  initial begin : stim
    rst_n = 1'b0;
    repeat (3) cycle(1, 1, 1, 1);
    check("rst_stall", 32'(ow_stall), 32'd0);
    check("rst_flush", 32'(ow_flush), 32'd0);
    check("rst_state", 32'(ow_state), 32'd0);
    rst_n = 1'b1;
    repeat (2) cycle(0, 0, 0, 0);

    cycle(1, 0, 0, 0);
    check("lu_state", 32'(ow_state), 32'd1);
    check("lu_stall", 32'(ow_stall), 32'b000011);
    check("lu_flush", 32'(ow_flush), 32'b000100);
    cycle(0, 0, 0, 0);
    check("lu_done", {ow_stall, ow_flush, 2'(ow_state)}, 14'd0);

    cycle(0, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      check("mc_stall", 32'(ow_stall), 32'b001111);
      check("mc_flush", 32'(ow_flush), 32'b010000);
      cycle(0, 0, (k == 1), 0);
    end
    check("mc_done", 32'(ow_state), 32'd0);

    cycle(1, 1, 1, 0);
    check("prio_state", 32'(ow_state), 32'd3);
    check("prio_flush", 32'(ow_flush), 32'b000111);
    cycle(0, 0, 1, 0);
    check("flush_again", 32'(ow_state), 32'd3);
    cycle(0, 0, 0, 0);
    check("flush_done", 32'(ow_state), 32'd0);

    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cycle(0, 0, 1, 1);
      check("mw_stall", 32'(ow_stall), 32'h3F);
      check("mw_flush", 32'(ow_flush), 32'd0);
    end
    cycle(0, 0, 0, 0);
    check("mw_resume", 32'(ow_state), 32'd2);
    cycle(0, 0, 0, 0);
    check("mw_last", 32'(ow_state), 32'd0);

    cycle(0, 1, 0, 0);
    check("pre_rst_busy", 32'(ow_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst", {ow_stall, ow_flush, ow_pc_hold, ow_busy, ow_state}, 16'd0);
`ifdef PIPE_SEQ_CTRL_PERF_EN
    check("perf_stall_rst", ow_stall_cnt, 32'd0);
    check("perf_flush_rst", ow_flush_cnt, 32'd0);
`endif
    cycle(0, 0, 0, 1);
    rst_n = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 6) == 0));
    end
    rst_n = 1'b1;
    repeat (3) cycle(0, 0, 0, 0);
    @(negedge clk);
    #5;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/pipe_seq_ctrl.md
Name: pipe_seq_ctrl

Overview:
- Central sequencer for the stage-latch pipeline (fetch through writeback, NUM_STG latches).
- Each stage latch is enabled by default. This block drives per-stage hold (stall) and bubble (flush-to-zero) controls to resolve load-use hazards, multicycle execute ops, branch redirects and memory wait.
- A bubble equals the stage latch's reset value (all zero pc/instr).

Parameters:
- NUM_STG, 6, number of stage latches controlled (bit 0 = fetch).
- HAZ_STG, 2, stage receiving the bubble on a load-use stall; stages below it hold.
- EX_STG, 3, multicycle execute stage; stages 0..EX_STG hold, EX_STG+1 receives bubbles.
- MC_LAT, 4, total cycles of a multicycle op; legal range 2..15.
- FLUSH_DEPTH, 3, number of youngest stages (0..FLUSH_DEPTH-1) zeroed on redirect.

Ports:
- iw_clk  in  1  clock, rising edge.
- iw_rst_n  in  1  asynchronous, active-low reset.
- iw_ld_use  in  1  load-use hazard detected this cycle.
- iw_mc_start  in  1  multicycle op issued into EX_STG.
- iw_branch_taken  in  1  redirect resolved; younger stages invalid.
- iw_mem_wait  in  1  memory not ready; freeze whole pipe.
- ow_stall  out  NUM_STG  per-stage hold (1 = latch keeps value).
- ow_flush  out  NUM_STG  per-stage bubble (1 = latch loads zero).
- ow_pc_hold  out  1  PC register hold; equals ow_stall[0].
- ow_busy  out  1  state != RUN.
- ow_state  out  2  RUN=0, LU=1, MC=2, FLUSH=3.

Behaviour:
- Reset (iw_rst_n=0, async): state RUN, mc counter 0, all outputs 0. Reset mid-MC or mid-FLUSH aborts immediately.
- Inputs are sampled on the rising edge. State outputs are Moore-decoded from the registered state, so they take effect the cycle after the request (latency 1).
- RUN: stall=0, flush=0. Next state by priority:
  - branch_taken -> FLUSH
  - else mc_start -> MC, counter loaded with MC_LAT-1
  - else ld_use -> LU
  - else RUN.
- LU (exactly 1 cycle): stall[HAZ_STG-1:0]=1, flush[HAZ_STG]=1. Next: branch_taken -> FLUSH, else RUN. mc_start and ld_use are ignored.
- MC: stall[EX_STG:0]=1, flush[EX_STG+1]=1 (when EX_STG+1 < NUM_STG). The counter decrements each cycle; at counter==1 the next state is RUN. Total MC occupancy is MC_LAT-1 cycles. branch_taken, ld_use and mc_start are ignored.
- FLUSH (1 cycle): flush[FLUSH_DEPTH-1:0]=1, stall=0. Next: branch_taken -> FLUSH again, else RUN. ld_use and mc_start are ignored, because the requesters are being flushed.
- iw_mem_wait=1 overrides everything combinationally:
  - ow_stall all ones, ow_flush all zeros.
  - State and counter frozen; inputs other than reset are ignored that cycle.
  - On release, the pending state output resumes unchanged.
- Invariant: no bit is set in both ow_stall and ow_flush in the same cycle.
- Counter width is 4 bits. It never wraps: it is loaded only on entry to MC and is decremented only while in MC.

Optional Feature:
- Macro: PIPE_SEQ_CTRL_PERF_EN.
- When defined, adds outputs ow_stall_cnt (32) and ow_flush_cnt (32), both reset to 0.
  - ow_stall_cnt increments on every cycle with any ow_stall bit set, including mem_wait freeze.
  - ow_flush_cnt increments on every cycle with any ow_flush bit set.
  - Both saturate at 0xFFFFFFFF.
- When not defined, the ports and logic are absent and the rest of the behaviour is identical.

Test Plan:
- Reset: hold iw_rst_n=0 with all inputs 1 -> all outputs 0, ow_state=0. Release -> RUN.
- Load-use: pulse ld_use 1 cycle -> next cycle ow_state=1, ow_stall=6'b000011, ow_flush=6'b000100. Following cycle RUN, all zero.
- Multicycle: pulse mc_start with MC_LAT=4 -> ow_stall=6'b001111 and ow_flush=6'b010000 for exactly 3 cycles, then RUN. A branch_taken pulse mid-MC has no effect.
- Priority: branch_taken, mc_start and ld_use together in RUN -> FLUSH, ow_flush=6'b000111 for 1 cycle. Back-to-back branch_taken keeps FLUSH.
- Memory wait: assert mem_wait for 3 cycles during MC (counter=2) -> ow_stall=6'b111111, ow_flush=0. After release, MC persists 2 more cycles, then RUN.
- Reset mid-op: drop iw_rst_n during MC -> outputs 0 asynchronously, without waiting for a clock edge. With PIPE_SEQ_CTRL_PERF_EN, both counters read 0.
